hazard_scoreboard_ctrl: RTL and testbench

- Scoreboard and stall controller for the decode stage of the 5-stage MIPS pipeline.
- Tracks outstanding register writes between ID issue and WB retirement.
- Detects RAW hazards on rs/rt and drives stall_if/stall_id/bubble_ex so IF/ID hold and EX receives a bubble.
- Replaces the ad-hoc per-register flag bits in decode with counted, handshaked bookkeeping plus a watchdog FSM.

---
 rtl/hazard_scoreboard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
//   Decode-stage scoreboard for the 5-stage MIPS pipeline. A small counter per
//   architectural register tracks writes that have issued from ID but not yet
//   retired in WB. RAW hazards on rs/rt and counter saturation on the
//   destination stall IF/ID and bubble EX. A watchdog FSM flags stalls that
//   never resolve.
//   Optional build macro: SCOREBOARD_PERF_EN adds stall/issue performance
//   counters (perf_stall_cnt, perf_issue_cnt).
module hazard_scoreboard_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int STALL_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_reg_write,
  input  logic [ADDR_W-1:0]   id_wr_addr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic                id_issue,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic [NUM_REGS-1:0] pending_vec,
  output logic [3:0]          stall_cycles,
  output logic                err_timeout,
  output logic                err_underflow
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_issue_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [3:0]       STALL_LIMIT = 4'(STALL_MAX);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    eff [NUM_REGS];
  logic [NUM_REGS-1:0] rel;
  logic [NUM_REGS-1:0] acq;
  logic                hazard;
  logic                rs_hit;
  logic                rt_hit;
  logic                wr_full;
  logic                stall_any;
  logic                underflow_hit;
  logic                set_timeout;
  state_t              state_q;
  state_t              state_d;
  logic [3:0]          stall_cycles_d;

  // Per-register WB release and the count as seen after this cycle's release.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rel[i]         = wb_valid && (wb_addr == ADDR_W'(i)) && (i != 0);
      eff[i]         = (cnt[i] != '0) ? cnt[i] - CNT_W'(rel[i]) : cnt[i];
      pending_vec[i] = (cnt[i] != '0);
    end
  end

  // Hazard detection: RAW on sources, or destination counter already full.
  always_comb begin
    rs_hit    = id_uses_rs && (id_rs != '0) && (eff[id_rs] != '0);
    rt_hit    = id_uses_rt && (id_rt != '0) && (eff[id_rt] != '0);
    wr_full   = id_reg_write && (id_wr_addr != '0) && (eff[id_wr_addr] == CNT_MAX);
    hazard    = rs_hit || rt_hit || wr_full;
    stall_any = (id_valid && hazard) || (state_q == ST_ERR);
    id_issue  = id_valid && !hazard && (state_q != ST_ERR);
    stall_if  = stall_any;
    stall_id  = stall_any;
    bubble_ex = stall_any;
  end

  // Acquire on issue of a register-writing instruction; detect underflow.
  always_comb begin
    underflow_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      acq[i] = id_issue && id_reg_write && (id_wr_addr == ADDR_W'(i)) && (i != 0);
      if (rel[i] && (cnt[i] == '0)) underflow_hit = 1'b1;
    end
  end

  // Outstanding-write counters: +acquire, -release (release ignored at zero).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these counters are discrete flops, not a RAM, so resetting the
      // whole array is legal and keeps pending_vec well defined after reset.
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (acq[i] && !(rel[i] && (cnt[i] != '0))) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!acq[i] && rel[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Watchdog next-state logic: count consecutive stall cycles, trap on limit.
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    stall_cycles_d = stall_cycles;
    set_timeout    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (id_valid && hazard) begin
          state_d        = ST_STALL;
          stall_cycles_d = 4'd1;
        end
      end
      ST_STALL: begin
        if (id_valid && hazard) begin
          if (stall_cycles == STALL_LIMIT) begin
            state_d     = ST_ERR;
            set_timeout = 1'b1;
          end else begin
            stall_cycles_d = stall_cycles + 4'd1;
          end
        end else begin
          state_d        = ST_RUN;
          stall_cycles_d = 4'd0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d        = ST_RUN;
        stall_cycles_d = 4'd0;
      end
    endcase
    if (flush) begin
      state_d        = ST_RUN;
      stall_cycles_d = 4'd0;
      set_timeout    = 1'b0;
    end
  end

  // Watchdog state and stall-cycle register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      stall_cycles <= 4'd0;
    end else begin
      state_q      <= state_d;
      stall_cycles <= stall_cycles_d;
    end
  end

  // Sticky error flags: cleared by reset only, flush leaves them intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (set_timeout) err_timeout <= 1'b1;
      if (!flush && underflow_hit) err_underflow <= 1'b1;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  // Free-running performance counters, wrap at 2^32, reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_issue_cnt <= 32'd0;
    end else begin
      if (stall_id) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl
//   Directed scenarios plus randomized traffic for hazard_scoreboard_ctrl,
//   compared against a count-array reference model of the scoreboard rules.
//   Define SCOREBOARD_PERF_EN to also exercise the performance counters.
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rs = 1'b0;
  logic        id_uses_rt = 1'b0;
  logic        id_reg_write = 1'b0;
  logic [4:0]  id_wr_addr = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        id_issue;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic [31:0] pending_vec;
  logic [3:0]  stall_cycles;
  logic        err_timeout;
  logic        err_underflow;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_issue_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain outstanding-write counts and a stall-run tracker.
  int          m_cnt [32];
  int          m_sc;
  int          m_mode;      // 0 running, 1 stalling, 2 trapped
  logic        m_eto;
  logic        m_eun;
  logic        m_hazard;
  logic        m_issue;
  logic        m_stall;
  logic [31:0] m_pend;

  hazard_scoreboard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_reg_write  (id_reg_write),
    .id_wr_addr    (id_wr_addr),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .id_issue      (id_issue),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .pending_vec   (pending_vec),
    .stall_cycles  (stall_cycles),
    .err_timeout   (err_timeout),
    .err_underflow (err_underflow)
`ifdef SCOREBOARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_issue_cnt(perf_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_eff(input int r);
    if (r != 0 && m_cnt[r] > 0 && wb_valid && int'(wb_addr) == r) return m_cnt[r] - 1;
    return m_cnt[r];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_sc = 0; m_mode = 0; m_eto = 1'b0; m_eun = 1'b0;
  endtask

  task automatic model_eval();
    m_hazard = (id_uses_rs && id_rs != 0 && m_eff(int'(id_rs)) != 0) ||
               (id_uses_rt && id_rt != 0 && m_eff(int'(id_rt)) != 0) ||
               (id_reg_write && id_wr_addr != 0 && m_eff(int'(id_wr_addr)) == 3);
    m_issue  = id_valid && !m_hazard && m_mode != 2;
    m_stall  = (id_valid && m_hazard) || m_mode == 2;
    for (int r = 0; r < 32; r++) m_pend[r] = (m_cnt[r] != 0);
  endtask

  task automatic model_clock();
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_sc = 0; m_mode = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        int acq, rel;
        acq = (m_issue && id_reg_write && int'(id_wr_addr) == r) ? 1 : 0;
        rel = (wb_valid && int'(wb_addr) == r && m_cnt[r] > 0) ? 1 : 0;
        if (wb_valid && int'(wb_addr) == r && m_cnt[r] == 0) m_eun = 1'b1;
        m_cnt[r] = m_cnt[r] + acq - rel;
      end
      if (m_mode == 0) begin
        if (id_valid && m_hazard) begin m_mode = 1; m_sc = 1; end
      end else if (m_mode == 1) begin
        if (id_valid && m_hazard) begin
          if (m_sc == 15) begin m_mode = 2; m_eto = 1'b1; end
          else m_sc++;
        end else begin
          m_mode = 0; m_sc = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic rw,
                       input logic [4:0] wa, input logic wbv, input logic [4:0] wba);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_reg_write = rw; id_wr_addr = wa; wb_valid = wbv; wb_addr = wba;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Let combinational outputs settle away from the clock edge.
  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advance one clock; returns on the following falling edge.
  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL reset_pending got %h exp 0", pending_vec); end
    n_checks++; if (stall_cycles !== 4'd0) begin n_errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    n_checks++; if ({err_timeout, err_underflow} !== 2'b00) begin n_errors++; $display("FAIL reset_err got %b exp 00", {err_timeout, err_underflow}); end
    n_checks++; if ({stall_if, stall_id, bubble_ex, id_issue} !== 4'b0000) begin n_errors++; $display("FAIL reset_ctrl got %b exp 0000", {stall_if, stall_id, bubble_ex, id_issue}); end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_raw();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0);
    settle();
    n_checks++; if (id_issue !== 1'b1) begin n_errors++; $display("FAIL raw_write_issue got %b exp 1", id_issue); end
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    n_checks++; if ({stall_if, stall_id, bubble_ex, id_issue} !== 4'b1110) begin n_errors++; $display("FAIL raw_stall got %b exp 1110", {stall_if, stall_id, bubble_ex, id_issue}); end
    n_checks++; if (pending_vec[3] !== 1'b1) begin n_errors++; $display("FAIL raw_pending3 got %b exp 1", pending_vec[3]); end
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    settle();
    n_checks++; if ({stall_id, id_issue} !== 2'b01) begin n_errors++; $display("FAIL raw_wb_bypass got %b exp 01", {stall_id, id_issue}); end
    tick();
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL raw_pending_clear got %h exp 0", pending_vec); end
    n_checks++; if (stall_cycles !== 4'd0) begin n_errors++; $display("FAIL raw_stall_cycles got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
      settle();
      n_checks++; if (id_issue !== 1'b1) begin n_errors++; $display("FAIL b2b_write_issue got %b exp 1", id_issue); end
      tick();
    end
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5);
    settle();
    n_checks++; if ({stall_id, id_issue} !== 2'b10) begin n_errors++; $display("FAIL b2b_first_wb got %b exp 10", {stall_id, id_issue}); end
    tick();
    settle();
    n_checks++; if ({stall_id, id_issue} !== 2'b01) begin n_errors++; $display("FAIL b2b_second_wb got %b exp 01", {stall_id, id_issue}); end
    n_checks++; if (stall_cycles !== 4'd1) begin n_errors++; $display("FAIL b2b_stall_cycles got %0d exp 1", stall_cycles); end
    tick();
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL b2b_pending got %h exp 0", pending_vec); end
  endtask

  task automatic test_r0();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
      settle();
      n_checks++; if ({stall_id, id_issue} !== 2'b01) begin n_errors++; $display("FAIL r0_no_stall got %b exp 01", {stall_id, id_issue}); end
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
    tick();
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL r0_pending got %h exp 0", pending_vec); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL r0_wb_ignored got %b exp 0", err_underflow); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    idle();
    settle();
    n_checks++; if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_flag got %b exp 1", err_underflow); end
    n_checks++; if (pending_vec[9] !== 1'b0) begin n_errors++; $display("FAIL uf_cnt9 got %b exp 0", pending_vec[9]); end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);
    settle();
    n_checks++; if (id_issue !== 1'b1) begin n_errors++; $display("FAIL uf_same_cycle_issue got %b exp 1", id_issue); end
    tick();
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0000_0010) begin n_errors++; $display("FAIL uf_net_zero got %h exp 00000010", pending_vec); end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4);
    tick();
    idle();
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL uf_cnt4_release got %h exp 0", pending_vec); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      settle();
      n_checks++; if (stall_id !== 1'b1) begin n_errors++; $display("FAIL to_stall_%0d got %b exp 1", k, stall_id); end
      n_checks++; if (stall_cycles !== 4'(k - 1)) begin n_errors++; $display("FAIL to_count_%0d got %0d exp %0d", k, stall_cycles, k - 1); end
      n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL to_early_%0d got %b exp 0", k, err_timeout); end
      tick();
    end
    idle();
    settle();
    n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL to_flag got %b exp 1", err_timeout); end
    n_checks++; if ({stall_if, stall_id, bubble_ex, id_issue} !== 4'b1110) begin n_errors++; $display("FAIL to_err_stall got %b exp 1110", {stall_if, stall_id, bubble_ex, id_issue}); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    n_checks++; if (pending_vec !== 32'h0) begin n_errors++; $display("FAIL to_flush_pending got %h exp 0", pending_vec); end
    n_checks++; if ({stall_id, stall_cycles} !== 5'd0) begin n_errors++; $display("FAIL to_flush_stall got %b exp 00000", {stall_id, stall_cycles}); end
    n_checks++; if ({err_timeout, err_underflow} !== 2'b11) begin n_errors++; $display("FAIL to_flush_keeps_err got %b exp 11", {err_timeout, err_underflow}); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    settle();
    n_checks++; if ({stall_id, stall_cycles} !== 5'b1_0010) begin n_errors++; $display("FAIL rst_pre got %b exp 10010", {stall_id, stall_cycles}); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin n_errors++; $display("FAIL rst_async_stall got %b exp 000", {stall_if, stall_id, bubble_ex}); end
    n_checks++; if ({pending_vec, stall_cycles, err_timeout, err_underflow} !== 38'h0) begin n_errors++; $display("FAIL rst_async_state got %h/%0d/%b%b exp 0", pending_vec, stall_cycles, err_timeout, err_underflow); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 49) == 0);
      settle();
      n_checks++; if ({stall_if, stall_id, bubble_ex} !== {3{m_stall}}) begin n_errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", n, {stall_if, stall_id, bubble_ex}, {3{m_stall}}); end
      n_checks++; if (id_issue !== m_issue) begin n_errors++; $display("FAIL rnd_issue[%0d] got %b exp %b", n, id_issue, m_issue); end
      n_checks++; if (pending_vec !== m_pend) begin n_errors++; $display("FAIL rnd_pending[%0d] got %h exp %h", n, pending_vec, m_pend); end
      n_checks++; if (stall_cycles !== 4'(m_sc)) begin n_errors++; $display("FAIL rnd_stall_cycles[%0d] got %0d exp %0d", n, stall_cycles, m_sc); end
      n_checks++; if ({err_timeout, err_underflow} !== {m_eto, m_eun}) begin n_errors++; $display("FAIL rnd_err[%0d] got %b exp %b", n, {err_timeout, err_underflow}, {m_eto, m_eun}); end
      tick();
    end
    flush = 1'b0;
    idle();
  endtask

`ifdef SCOREBOARD_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    idle();
    settle();
    n_checks++; if (perf_stall_cnt !== 32'd3) begin n_errors++; $display("FAIL perf_stall got %0d exp 3", perf_stall_cnt); end
    n_checks++; if (perf_issue_cnt !== 32'd2) begin n_errors++; $display("FAIL perf_issue got %0d exp 2", perf_issue_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_raw();
    test_back_to_back();
    test_r0();
    test_underflow();
    test_timeout();
    test_reset_mid_stall();
    test_random();
`ifdef SCOREBOARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
